// File: rtl/eye_frame_capture.sv
// eye_frame_capture: writes camera frames into a two-bank (ping-pong) image
// buffer. A frame must start with pix_sof. A frame is presented to
// pupil_detect once its last pixel has been written, and stays presented
// until frame_release.
module eye_frame_capture #(
  parameter int IMG_W = 112,
  parameter int IMG_H = 112,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             pix_valid,
  input  logic             pix_sof,
  input  logic [PIX_W-1:0] pix_data,
  output logic             buf_wr_en,
  output logic [14:0]      buf_wr_addr,
  output logic [PIX_W-1:0] buf_wr_data,
  output logic             frame_ready,
  output logic             frame_bank,
  input  logic             frame_release,
  output logic             busy,
  output logic             short_err,
  output logic [7:0]       drop_cnt
);

  localparam logic [13:0] LAST_IDX = 14'(IMG_W * IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOF = 2'd1,
    CAPTURE  = 2'd2
  } state_t;

  state_t      state;
  logic [1:0]  full;
  logic        wr_bank;
  logic        rd_bank;
  logic [13:0] pix_idx;     // index the next non-sof pixel is written to
  logic        done_q;      // final write of a frame is on the bus this cycle
  logic        done_bank;

  logic        rel;
  logic        wr_go;
  logic        last_pix;
  logic [13:0] wr_idx;
  logic [1:0]  rel_mask;
  logic [1:0]  done_mask;
  logic [1:0]  full_nxt;
  logic        rd_nxt;

  // A bank is marked full only once its final write is on the bus. As a
  // result, frame_ready rises one cycle after the last buf_wr_en.
  // Release and completion always target different banks, so the two
  // masks never collide.
  always_comb begin
    rel      = frame_release && full[rd_bank];
    wr_go    = 1'b0;
    wr_idx   = '0;
    last_pix = 1'b0;
    if (enable && pix_valid) begin
      case (state)
        WAIT_SOF: wr_go = pix_sof && !full[wr_bank];
        CAPTURE: begin
          wr_go = 1'b1;
          if (!pix_sof) begin
            wr_idx   = pix_idx;
            last_pix = (pix_idx == LAST_IDX);
          end
        end
        default: ;
      endcase
    end
    rel_mask  = {rel && rd_bank, rel && !rd_bank};
    done_mask = {done_q && done_bank, done_q && !done_bank};
    full_nxt  = (full & ~rel_mask) | done_mask;
    rd_nxt    = rd_bank ^ rel;
  end

  assign busy = (state == CAPTURE);

  // Capture FSM, bank bookkeeping and registered buffer/presentation outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      full        <= 2'b00;
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      pix_idx     <= '0;
      done_q      <= 1'b0;
      done_bank   <= 1'b0;
      buf_wr_en   <= 1'b0;
      buf_wr_addr <= '0;
      buf_wr_data <= '0;
      frame_ready <= 1'b0;
      frame_bank  <= 1'b0;
      short_err   <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      buf_wr_en <= wr_go;
      if (wr_go) begin
        buf_wr_addr <= {wr_bank, wr_idx};
        buf_wr_data <= pix_data;
      end
      done_q      <= last_pix;
      done_bank   <= wr_bank;
      full        <= full_nxt;
      rd_bank     <= rd_nxt;
      frame_ready <= full_nxt[rd_nxt];
      frame_bank  <= rd_nxt;

      case (state)
        IDLE: begin
          if (enable) state <= WAIT_SOF;
        end
        WAIT_SOF: begin
          if (!enable) begin
            state <= IDLE;
          end else if (pix_valid && pix_sof) begin
            if (full[wr_bank]) begin
              if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end else begin
              state   <= CAPTURE;
              pix_idx <= 14'd1;
            end
          end
        end
        CAPTURE: begin
          if (!enable) begin
            state   <= IDLE;
            pix_idx <= '0;
          end else if (pix_valid) begin
            if (pix_sof) begin
              short_err <= 1'b1;
              pix_idx   <= 14'd1;
            end else if (last_pix) begin
              wr_bank <= ~wr_bank;
              state   <= WAIT_SOF;
              pix_idx <= '0;
            end else begin
              pix_idx <= pix_idx + 14'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eye_frame_capture.sv
// Directed bench for eye_frame_capture on a reduced 16x12 frame.
module tb_eye_frame_capture;

  localparam int W = 16;
  localparam int H = 12;
  localparam int N = W * H;
  localparam logic [14:0] LAST0 = 15'(N - 1);
  localparam logic [14:0] LAST1 = 15'h4000 | 15'(N - 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic        buf_wr_en;
  logic [14:0] buf_wr_addr;
  logic [7:0]  buf_wr_data;
  logic        frame_ready;
  logic        frame_bank;
  logic        frame_release;
  logic        busy;
  logic        short_err;
  logic [7:0]  drop_cnt;

  int tests = 0;
  int fails = 0;

  logic [14:0] alog[$];
  logic [7:0]  dlog[$];

  eye_frame_capture #(.IMG_W(W), .IMG_H(H), .PIX_W(8)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pix_valid(pix_valid),
    .pix_sof(pix_sof), .pix_data(pix_data), .buf_wr_en(buf_wr_en),
    .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .frame_ready(frame_ready), .frame_bank(frame_bank),
    .frame_release(frame_release), .busy(busy), .short_err(short_err),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // log every buffer write away from the active edge
  always @(negedge clk) begin
    if (buf_wr_en === 1'b1) begin
      alog.push_back(buf_wr_addr);
      dlog.push_back(buf_wr_data);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input bit sof, input int idx);
    pix_valid = 1'b1;
    pix_sof   = sof;
    pix_data  = idx[7:0];
    cyc();
    pix_valid = 1'b0;
    pix_sof   = 1'b0;
  endtask

  task automatic send_frame(input int gap);
    for (int i = 0; i < N; i++) begin
      pix(i == 0, i);
      repeat (gap) cyc();
    end
  endtask

  task automatic release_frame();
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] obs;
    obs = {buf_wr_en, buf_wr_addr, buf_wr_data, frame_ready, frame_bank,
           busy, short_err, drop_cnt};
    tests++;
    if (obs !== 36'd0) begin
      fails++;
      $display("FAIL reset_values: got %h expected 0", obs);
    end
  endtask

  task automatic test_single_frame();
    int n0;
    int brk;
    n0 = alog.size();
    for (int i = 0; i < 5; i++) pix(1'b0, i + 7);
    cyc();
    tests++;
    if (alog.size() != n0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL ignore_no_sof: writes %0d busy %b expected 0 0", alog.size() - n0, busy);
    end
    for (int i = 0; i < N; i++) begin
      pix(i == 0, i);
      if (i == 10) begin
        tests++;
        if (busy !== 1'b1) begin
          fails++;
          $display("FAIL busy_capture: got %b expected 1", busy);
        end
      end
    end
    tests++;
    if (buf_wr_en !== 1'b1 || buf_wr_addr !== LAST0 || frame_ready !== 1'b0) begin
      fails++;
      $display("FAIL last_write: en %b addr %h ready %b expected 1 %h 0",
               buf_wr_en, buf_wr_addr, frame_ready, LAST0);
    end
    cyc();
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL single_ready: ready %b bank %b busy %b expected 1 0 0",
               frame_ready, frame_bank, busy);
    end
    brk = 0;
    if (alog.size() - n0 != N) brk = -1;
    else
      for (int k = 0; k < N; k++)
        if (alog[n0+k] !== 15'(k) || dlog[n0+k] !== 8'(k)) brk++;
    tests++;
    if (brk != 0) begin
      fails++;
      $display("FAIL single_addrs: bad %0d writes %0d expected 0 bad %0d writes", brk, alog.size() - n0, N);
    end
  endtask

  task automatic test_ping_pong();
    int n;
    release_frame();
    cyc();
    tests++;
    if (frame_ready !== 1'b0 || frame_bank !== 1'b1) begin
      fails++;
      $display("FAIL release0: ready %b bank %b expected 0 1", frame_ready, frame_bank);
    end
    release_frame();
    cyc();
    tests++;
    if (frame_ready !== 1'b0 || frame_bank !== 1'b1) begin
      fails++;
      $display("FAIL release_ignored: ready %b bank %b expected 0 1", frame_ready, frame_bank);
    end
    n = alog.size();
    send_frame(0);
    cyc();
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b1 || alog.size() - n != N ||
        alog[n] !== 15'h4000 || alog[n+N-1] !== LAST1) begin
      fails++;
      $display("FAIL frame2_bank1: ready %b bank %b writes %0d first %h expected 1 1 %0d 4000",
               frame_ready, frame_bank, alog.size() - n, alog[n], N);
    end
    release_frame();
    n = alog.size();
    send_frame(0);
    cyc();
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || alog.size() - n != N ||
        alog[n] !== 15'h0000 || alog[n+N-1] !== LAST0) begin
      fails++;
      $display("FAIL frame3_bank0: ready %b bank %b writes %0d first %h expected 1 0 %0d 0000",
               frame_ready, frame_bank, alog.size() - n, alog[n], N);
    end
    release_frame();
    cyc();
    tests++;
    if (drop_cnt !== 8'd0 || frame_ready !== 1'b0 || frame_bank !== 1'b1) begin
      fails++;
      $display("FAIL pingpong_end: drop %0d ready %b bank %b expected 0 0 1",
               drop_cnt, frame_ready, frame_bank);
    end
  endtask

  task automatic test_overflow();
    int n;
    send_frame(0);
    send_frame(0);
    cyc();
    cyc();
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b1) begin
      fails++;
      $display("FAIL both_full: ready %b bank %b expected 1 1", frame_ready, frame_bank);
    end
    n = alog.size();
    pix(1'b1, 0);
    cyc();
    tests++;
    if (alog.size() != n || drop_cnt !== 8'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL first_drop: writes %0d drop %0d busy %b expected 0 1 0",
               alog.size() - n, drop_cnt, busy);
    end
    for (int i = 0; i < 253; i++) pix(1'b1, 0);
    cyc();
    tests++;
    if (drop_cnt !== 8'd254) begin
      fails++;
      $display("FAIL drop_254: got %0d expected 254", drop_cnt);
    end
    for (int i = 0; i < 47; i++) pix(1'b1, 0);
    cyc();
    tests++;
    if (drop_cnt !== 8'd255 || alog.size() != n) begin
      fails++;
      $display("FAIL drop_saturate: drop %0d writes %0d expected 255 0", drop_cnt, alog.size() - n);
    end
  endtask

  task automatic test_short_and_simultaneous();
    int n;
    release_frame();
    cyc();
    tests++;
    if (short_err !== 1'b0 || frame_ready !== 1'b1 || frame_bank !== 1'b0) begin
      fails++;
      $display("FAIL pre_short: err %b ready %b bank %b expected 0 1 0",
               short_err, frame_ready, frame_bank);
    end
    n = alog.size();
    for (int i = 0; i < 100; i++) pix(i == 0, i);
    pix(1'b1, 0);
    tests++;
    if (buf_wr_en !== 1'b1 || buf_wr_addr !== 15'h4000 || short_err !== 1'b1) begin
      fails++;
      $display("FAIL short_restart: en %b addr %h err %b expected 1 4000 1",
               buf_wr_en, buf_wr_addr, short_err);
    end
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b0) begin
      fails++;
      $display("FAIL short_full_kept: ready %b bank %b expected 1 0", frame_ready, frame_bank);
    end
    for (int i = 1; i < N; i++) pix(1'b0, i);
    frame_release = 1'b1;
    cyc();
    frame_release = 1'b0;
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b1) begin
      fails++;
      $display("FAIL simultaneous: ready %b bank %b expected 1 1", frame_ready, frame_bank);
    end
    tests++;
    if (alog.size() - n != 100 + N || alog[n+100] !== 15'h4000 || alog[n+99+N] !== LAST1) begin
      fails++;
      $display("FAIL short_writes: writes %0d expected %0d", alog.size() - n, 100 + N);
    end
    release_frame();
    tests++;
    if (frame_ready !== 1'b0 || frame_bank !== 1'b0 || short_err !== 1'b1) begin
      fails++;
      $display("FAIL after_simul_release: ready %b bank %b err %b expected 0 0 1",
               frame_ready, frame_bank, short_err);
    end
  endtask

  task automatic test_reset_mid_and_gapped();
    int n;
    int brk;
    logic [35:0] obs;
    send_frame(0);
    cyc();
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b0) begin
      fails++;
      $display("FAIL prefill_bank0: ready %b bank %b expected 1 0", frame_ready, frame_bank);
    end
    for (int i = 0; i < 150; i++) pix(i == 0, i);
    tests++;
    if (busy !== 1'b1 || buf_wr_addr !== 15'h4095) begin
      fails++;
      $display("FAIL mid_frame: busy %b addr %h expected 1 4095", busy, buf_wr_addr);
    end
    pix_valid = 1'b1;
    pix_sof   = 1'b0;
    pix_data  = 8'd150;
    reset = 1'b1;
    #2;
    obs = {buf_wr_en, buf_wr_addr, buf_wr_data, frame_ready, frame_bank,
           busy, short_err, drop_cnt};
    tests++;
    if (obs !== 36'd0) begin
      fails++;
      $display("FAIL async_reset: got %h expected 0", obs);
    end
    #2;
    reset = 1'b0;
    n = alog.size();
    for (int i = 0; i < 10; i++) pix(1'b0, 151 + i);
    cyc();
    tests++;
    if (alog.size() != n || busy !== 1'b0 || frame_ready !== 1'b0) begin
      fails++;
      $display("FAIL post_reset_quiet: writes %0d busy %b ready %b expected 0 0 0",
               alog.size() - n, busy, frame_ready);
    end
    n = alog.size();
    send_frame(2);
    cyc();
    tests++;
    if (frame_ready !== 1'b1 || frame_bank !== 1'b0 || short_err !== 1'b0) begin
      fails++;
      $display("FAIL gapped_ready: ready %b bank %b err %b expected 1 0 0",
               frame_ready, frame_bank, short_err);
    end
    brk = 0;
    if (alog.size() - n != N) brk = -1;
    else
      for (int k = 0; k < N; k++)
        if (alog[n+k] !== 15'(k) || dlog[n+k] !== 8'(k)) brk++;
    tests++;
    if (brk != 0) begin
      fails++;
      $display("FAIL gapped_addrs: bad %0d writes %0d expected 0 bad %0d writes", brk, alog.size() - n, N);
    end
  endtask

  initial begin
    reset = 1'b1;
    enable = 1'b0;
    pix_valid = 1'b0;
    pix_sof = 1'b0;
    pix_data = 8'd0;
    frame_release = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset = 1'b0;
    enable = 1'b1;
    cyc();
    test_single_frame();
    test_ping_pong();
    test_overflow();
    test_short_and_simultaneous();
    test_reset_mid_and_gapped();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
